// File: rtl/mem_responder.sv
// Valid/ready memory responder: a single outstanding word request,
// serviced from an internal RAM after a fixed latency.
module mem_responder #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [31:0]        req_addr,
  input  logic               req_write,
  input  logic [WIDTH-1:0]   req_wdata,
  input  logic [WIDTH/8-1:0] req_strb,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [WIDTH-1:0]   resp_data,
  output logic               resp_error
);

  localparam int NB = WIDTH / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t          state;
  state_t          state_d;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_d;

  logic            accept;
  logic            retire;
  logic            addr_err;
  logic            wr_en;
  logic [AW-1:0]   word_idx;
  logic [31:0]     addr_hi;

  logic [WIDTH-1:0] mem [DEPTH];

  assign word_idx = req_addr[AW+1:2];
  assign addr_hi  = req_addr >> (AW + 2);
  assign addr_err = (req_addr[1:0] != 2'b00)
                 || (addr_hi != '0);

  assign resp_valid = (state == RESP);

  // Held low while reset is asserted so nothing is offered during reset.
  assign req_ready = reset
                  && ((state == IDLE)
                   || ((state == RESP) && resp_ready));

  assign accept = req_valid && req_ready;
  assign retire = resp_valid && resp_ready;
  assign wr_en  = accept && req_write && !addr_err;

  always_comb begin
    state_d = state;
    count_d = count;
    unique case (state)
      IDLE: begin
        if (accept) begin
          count_d = CW'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        count_d = count - 1'b1;
        if (count == CW'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (retire) begin
          if (accept) begin
            count_d = CW'(LATENCY - 1);
            state_d = (LATENCY == 1) ? RESP : WAIT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_d;
      count <= count_d;
    end
  end

  // Response captured at accept; stays stable until retire.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_data  <= '0;
      resp_error <= 1'b0;
    end else if (accept) begin
      resp_error <= addr_err;
      if (addr_err || req_write) begin
        resp_data <= '0;
      end else begin
        resp_data <= mem[word_idx];
      end
    end else if (retire) begin
      resp_data  <= '0;
      resp_error <= 1'b0;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (req_strb[i]) begin
          mem[word_idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: reset, read/write, strobes,
// errors, backpressure and reset during a pending request.
module tb_mem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_error;

  int errors = 0;
  int checks = 0;

  mem_responder #(
    .WIDTH(32),
    .DEPTH(1024),
    .LATENCY(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .req_write(req_write),
    .req_wdata(req_wdata),
    .req_strb(req_strb),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data(resp_data),
    .resp_error(resp_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request with resp_ready=1; returns the response and the
  // latency (1 = visible right after the accept edge); lat=-1 on timeout.
  task automatic xact(
    input  logic        w,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic [3:0]  s,
    output logic [31:0] rd,
    output logic        re,
    output int          lat
  );
    int n;
    rd = '0;
    re = 1'b0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_wdata  = d;
    req_strb   = s;
    resp_ready = 1'b1;
    #1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!req_ready) begin
      req_valid = 1'b0;
      lat = -1;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!resp_valid) begin
      lat = -1;
      return;
    end
    rd = resp_data;
    re = resp_error;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset     = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h0;
    req_wdata = '0;
    req_strb  = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0) begin
        errors++;
        $display("FAIL rst_ready[%0d] got=%b exp=0", i, req_ready);
      end
      checks++;
      if (resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_valid[%0d] got=%b exp=0", i, resp_valid);
      end
      checks++;
      if (resp_data !== 32'h0) begin
        errors++;
        $display("FAIL rst_data[%0d] got=%h exp=0", i, resp_data);
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_release_ready got=%b exp=1", req_ready);
    end
  endtask

  task automatic test_write_read;
    logic [31:0] rd;
    logic        re;
    int          lat;
    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, re, lat);
    checks++;
    if (lat !== 2 || rd !== 32'h0 || re !== 1'b0) begin
      errors++;
      $display("FAIL wr_resp got lat=%0d data=%h err=%b exp lat=2 data=0 err=0",
               lat, rd, re);
    end
    xact(1'b0, 32'h10, 32'h0, 4'h0, rd, re, lat);
    checks++;
    if (lat !== 2 || rd !== 32'hDEADBEEF || re !== 1'b0) begin
      errors++;
      $display("FAIL rd_resp got lat=%0d data=%h err=%b exp lat=2 data=deadbeef err=0",
               lat, rd, re);
    end
  endtask

  task automatic test_strobes;
    logic [31:0] rd;
    logic        re;
    int          lat;
    xact(1'b1, 32'h20, 32'h11223344, 4'hF, rd, re, lat);
    xact(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, rd, re, lat);
    xact(1'b0, 32'h20, 32'h0, 4'h0, rd, re, lat);
    checks++;
    if (rd !== 32'h11BB33DD || re !== 1'b0) begin
      errors++;
      $display("FAIL strb_merge got=%h err=%b exp=11bb33dd err=0", rd, re);
    end
    xact(1'b1, 32'h10, 32'h0, 4'h0, rd, re, lat);
    xact(1'b0, 32'h10, 32'h0, 4'h0, rd, re, lat);
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL strb_zero got=%h exp=deadbeef", rd);
    end
  endtask

  task automatic test_errors;
    logic [31:0] rd;
    logic        re;
    int          lat;
    xact(1'b0, 32'h22, 32'h0, 4'h0, rd, re, lat);
    checks++;
    if (lat !== 2 || rd !== 32'h0 || re !== 1'b1) begin
      errors++;
      $display("FAIL err_misalign got lat=%0d data=%h err=%b exp lat=2 data=0 err=1",
               lat, rd, re);
    end
    xact(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, re, lat);
    xact(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, rd, re, lat);
    checks++;
    if (rd !== 32'h0 || re !== 1'b1) begin
      errors++;
      $display("FAIL err_range got data=%h err=%b exp data=0 err=1", rd, re);
    end
    xact(1'b0, 32'h0, 32'h0, 4'h0, rd, re, lat);
    checks++;
    if (rd !== 32'hCAFEF00D || re !== 1'b0) begin
      errors++;
      $display("FAIL err_word0 got=%h err=%b exp=cafef00d err=0", rd, re);
    end
    xact(1'b0, 32'h0000_0FFC, 32'h0, 4'h0, rd, re, lat);
    checks++;
    if (re !== 1'b0) begin
      errors++;
      $display("FAIL err_top_word got err=%b exp=0", re);
    end
  endtask

  task automatic test_backpressure;
    int n;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = 32'h20;
    resp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_addr = 32'h10;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_timeout got resp_valid=%b exp=1", resp_valid);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== 32'h11BB33DD
          || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d] got v=%b d=%h rdy=%b exp v=1 d=11bb33dd rdy=0",
                 i, resp_valid, resp_data, req_ready);
      end
    end
    @(negedge clk);
    resp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready got=%b exp=1", req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_retire got v=%b exp=0", resp_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL bp_next got v=%b d=%h exp v=1 d=deadbeef",
               resp_valid, resp_data);
    end
    @(posedge clk);
    #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_idle got v=%b rdy=%b exp v=0 rdy=1",
               resp_valid, req_ready);
    end
  endtask

  task automatic test_reset_in_wait;
    logic [31:0] rd;
    logic        re;
    int          lat;
    int          seen;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_addr   = 32'h30;
    req_wdata  = 32'h5A5A1234;
    req_strb   = 4'hF;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rst_wait_noresp got cycles=%0d exp=0", seen);
    end
    xact(1'b0, 32'h30, 32'h0, 4'h0, rd, re, lat);
    checks++;
    if (rd !== 32'h5A5A1234 || re !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_commit got=%h err=%b exp=5a5a1234 err=0", rd, re);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_strobes();
    test_errors();
    test_backpressure();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Valid/ready memory responder: the target end of the load/store request stream that pipeline stages issue through their skid buffers. It accepts one word-addressed read or byte-masked write request, services it from an internal synchronous RAM after a fixed latency, and returns a single response per request. One request is in flight at a time; back-to-back throughput is one request per LATENCY+1 cycles, or one per LATENCY cycles when the response is consumed immediately.

## Interface
- WIDTH, 32: data width in bits; must be a multiple of 8.
- DEPTH, 1024: RAM depth in words; must be a power of 2.
- LATENCY, 2: cycles from request acceptance to resp_valid; must be ≥1.
- clk  input  1  clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset; one clock domain.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept this cycle.
- req_addr  input  32  byte address.
- req_write  input  1  1 = write, 0 = read.
- req_wdata  input  WIDTH  write data.
- req_strb  input  WIDTH/8  byte write enables; bit i covers bits [8i+7:8i].
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer takes response.
- resp_data  output  WIDTH  read data; 0 for writes and errors.
- resp_error  output  1  request was misaligned or out of range.

## Operation
- accept = req_valid && req_ready; retire = resp_valid && resp_ready.
- States: IDLE, WAIT, RESP.
- req_ready is combinational: 1 in IDLE; 1 in RESP when resp_ready=1; 0 otherwise (including in WAIT).
- IDLE: on accept, go to WAIT with count = LATENCY-1; if LATENCY=1, go directly to RESP.
- WAIT: decrement count each cycle; at count=1, go to RESP on the next edge. resp_valid is 0 in this state.
- RESP: resp_valid=1.
  - retire without accept: go to IDLE.
  - retire with accept: treat the new request as accepted from IDLE.
  - no retire: hold the state; resp_data and resp_error stay stable.
- Word index = req_addr[log2(DEPTH)+1:2].
- Error when req_addr[1:0]≠0, or when any req_addr bit above log2(DEPTH)+1 is set.
- Errored request: no RAM access; resp_error=1, resp_data=0.
- Write: bytes with req_strb set are written to RAM at the accept edge. resp_data=0, resp_error=0. A strobe of all zeros is legal and writes nothing.
- Read: RAM word is read at the accept edge. Response is captured in an output register, held until retire.
- Request fields are sampled only at accept; they are don't-care otherwise.

## Timing
- Reset (asynchronous assert, synchronous-release usage):
  - state=IDLE, resp_valid=0, resp_data=0, resp_error=0, count=0.
  - req_ready returns 1 once reset deasserts.
- RAM contents are not reset: undefined at power-up, preserved across reset.
- Accept at edge T → resp_valid rises after edge T+LATENCY-1. With LATENCY=2, resp_valid is high in the second cycle after acceptance.
- Read-after-write to the same address always returns the new data (single outstanding request).
- Reset mid-operation:
  - Any pending or unretired response is discarded.
  - A write accepted before reset remains committed.
- resp_valid never drops without retire, except under reset.

## Test plan
- Reset: hold reset=0 for 3 cycles with req_valid=1 → req_ready=0 during reset, resp_valid=0 and resp_data=0 throughout; req_ready=1 the first cycle after release.
- Write then read, LATENCY=2, resp_ready=1:
  - write addr 0x10, data 0xDEADBEEF, strb 0xF → response with resp_data=0 and resp_error=0, 2 cycles after accept.
  - read addr 0x10 → resp_data=0xDEADBEEF.
- Byte strobes:
  - write 0x11223344 to addr 0x20 with strb 0xF, then 0xAABBCCDD with strb 0x5.
  - read addr 0x20 → 0x11BB33DD.
- Errors:
  - read addr 0x22 → resp_error=1, resp_data=0.
  - with DEPTH=1024, write addr 0x1000 → resp_error=1, and RAM word 0 is unchanged on readback.
- Backpressure: hold resp_ready=0 for 5 cycles with a read response pending → resp_valid stays 1, data stable, req_ready=0; raise resp_ready with req_valid=1 → retire and accept in the same cycle.
- Reset while in WAIT after a write accept → no response appears after release; a later read of that address returns the written data.
